stage4_query_ctrl: RTL and testbench
====================================

STAGE4_QUERY_CTRL -- requirements
Module: stage4_query_ctrl

Interface
REQ-001 SHALL have parameter DW, default 64, meaning item and latency word width matching the stage-4 search port.
REQ-002 SHALL have parameter LW, default 8, meaning latency-bucket index width.
REQ-003 SHALL have parameter CW, default 8, meaning hit-count and target width.
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports: clk in 1, clock; rst in 1, synchronous active-high reset.
REQ-005 SHALL have ports query_i in 1, request pulse; query_item_i in DW, item key; query_target_i in CW, required hit count; query_lat_lo_i / query_lat_hi_i in LW, inclusive bucket range.
REQ-006 SHALL have ports query_ready_o out 1, idle; query_done_o out 1, one-cycle completion pulse; query_found_o out 1, target reached; query_latency_o out LW, bucket where target was reached; query_hits_o out CW, accumulated hits.
REQ-007 SHALL have ports insert_busy_i in 1, stage-4 insert this cycle; search_a_o out 1; search_a_data_o out DW; search_a_latency_o out DW, bucket index zero-extended; search_a_freq_i in 1; search_a_end_i in 1.

Function
REQ-008 SHALL implement FSM IDLE, ISSUE, DRAIN, DONE; query_ready_o=1 only in IDLE.
REQ-009 SHALL, in IDLE on query_i=1, latch item, target, lo, hi; clear hits; set cur=lo; go to ISSUE. query_i outside IDLE SHALL be ignored.
REQ-010 SHALL, if the latched target=0, go directly to DONE with found=1, latency=lo, no probes.
REQ-011 SHALL, if the latched lo>hi, go directly to DONE with found=0, latency=0, no probes.
REQ-012 SHALL, in ISSUE while insert_busy_i=0 and the tag FIFO is not full, assert search_a_o for one cycle with the latched item and cur; push cur into the tag FIFO; then increment cur.
REQ-013 SHALL hold search_a_o=0 while insert_busy_i=1; cur SHALL stay unchanged.
REQ-014 SHALL use an LW+1-bit cur so that hi=2^LW-1 terminates without wrap-around; after issuing hi, go to DRAIN.
REQ-015 SHALL, on each search_a_end_i with a non-empty FIFO, pop one tag; if not yet found, hits+=search_a_freq_i, saturating at 2^CW-1.
REQ-016 SHALL, on the pop where the new hits value equals target, set found=1 and latency=popped tag; from the next cycle no further probes SHALL be issued (ISSUE->DRAIN).
REQ-017 SHALL ignore freq of results popped after found=1, while still popping them.
REQ-018 SHALL, in DRAIN, wait for an empty FIFO, then go to DONE.
REQ-019 SHALL, in DONE, pulse query_done_o for exactly one cycle, then return to IDLE. Result outputs SHALL hold until the next accepted query.
REQ-020 SHALL ignore search_a_end_i while the FIFO is empty. This covers stale results after reset.
REQ-021 SHALL have a probe-issue-to-result latency of 2 cycles; the FIFO depth of 4 SHALL sustain one probe per cycle.

Reset
REQ-022 SHALL, on rst=1 (any state, including mid-query), go to IDLE; all outputs 0 except query_ready_o=1; flush the FIFO; clear hits, cur and results.

Configuration
REQ-023 SHALL, with STAGE4_QUERY_PROBE_CNT_EN defined, add output query_probes_o (LW+1 bits), the number of probes issued by the last query, cleared at query accept and at reset.
REQ-024 SHALL, without STAGE4_QUERY_PROBE_CNT_EN, have neither the port nor the counter; behaviour is otherwise identical.

Structure
REQ-025 SHALL take DW/LW/CW defaults, the FSM state typedef, and TAG_FIFO_DEPTH=4 from shared package stage4_pkg.
REQ-026 SHALL instantiate one sub-module, stage4_tag_fifo: a synchronous FIFO of LW-bit tags with push, pop, full and empty.

Verification
REQ-027 SHALL cover: lo=0, hi=7, target=3, and a stub returning freq=1 for buckets 2,4,5 -> done with found=1, latency=5, hits=3, and no probe issued after the cycle following the bucket-5 result.
REQ-028 SHALL cover: lo=0, hi=3, target=2, freq=1 only at bucket 1 -> 4 probes, done with found=0, hits=1.
REQ-029 SHALL cover: target=0 -> done 1 cycle after accept, found=1, latency=lo, zero probes; and lo=9, hi=3 -> found=0, zero probes.
REQ-030 SHALL cover: insert_busy_i high for cycles 2-4 of ISSUE -> no search_a_o in those cycles, and the bucket sequence is contiguous, with no gap or duplicate.
REQ-031 SHALL cover: lo=250, hi=255, LW=8, all freq=0 -> exactly 6 probes, terminates, found=0.
REQ-032 SHALL cover: rst asserted mid-ISSUE with 2 results in flight -> ready=1 the next cycle, stale search_a_end_i ignored, and the next query is correct.

Source files
------------

// File: rtl/stage4_pkg.sv
// Shared definitions for the stage-4 query controller: default widths,
// tag FIFO depth and the controller state encoding.
package stage4_pkg;

  localparam int DEF_DW         = 64;
  localparam int DEF_LW         = 8;
  localparam int DEF_CW         = 8;
  localparam int TAG_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } q_state_t;

endpackage

// File: rtl/stage4_tag_fifo.sv
// Synchronous FIFO holding the bucket tags of probes whose results are still
// outstanding. DEPTH must be a power of two so the pointers wrap naturally.
module stage4_tag_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/stage4_query_ctrl.sv
// Stage-4 latency query: probes buckets lo..hi, accumulates hit flags until the
// target count is reached. STAGE4_QUERY_PROBE_CNT_EN adds a probe counter output.
module stage4_query_ctrl
  import stage4_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int LW = DEF_LW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          query_i,
  input  logic [DW-1:0] query_item_i,
  input  logic [CW-1:0] query_target_i,
  input  logic [LW-1:0] query_lat_lo_i,
  input  logic [LW-1:0] query_lat_hi_i,
  output logic          query_ready_o,
  output logic          query_done_o,
  output logic          query_found_o,
  output logic [LW-1:0] query_latency_o,
  output logic [CW-1:0] query_hits_o,
`ifdef STAGE4_QUERY_PROBE_CNT_EN
  output logic [LW:0]   query_probes_o,
`endif
  input  logic          insert_busy_i,
  output logic          search_a_o,
  output logic [DW-1:0] search_a_data_o,
  output logic [DW-1:0] search_a_latency_o,
  input  logic          search_a_freq_i,
  input  logic          search_a_end_i
);

  q_state_t      state;
  logic [DW-1:0] item_q;
  logic [CW-1:0] target_q;
  logic [LW-1:0] lo_q;
  logic [LW-1:0] hi_q;
  logic [LW:0]   cur;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] pop_tag;
  logic          issue_fire;
  logic          pop;
  logic [CW:0]   hits_sum;
  logic [CW-1:0] hits_next;

  // The search port is driven combinationally so an insert in the same cycle blocks the probe.
  assign issue_fire = (state == S_ISSUE) && !query_found_o && (target_q != '0) &&
                      (lo_q <= hi_q) && !insert_busy_i && !fifo_full;
  assign pop        = search_a_end_i && !fifo_empty;
  assign hits_sum   = {1'b0, query_hits_o} + {{CW{1'b0}}, search_a_freq_i};
  assign hits_next  = hits_sum[CW] ? '1 : hits_sum[CW-1:0];

  assign search_a_o         = issue_fire;
  assign search_a_data_o    = item_q;
  assign search_a_latency_o = {{(DW-LW){1'b0}}, cur[LW-1:0]};

  stage4_tag_fifo #(
    .W     (LW),
    .DEPTH (TAG_FIFO_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue_fire),
    .push_data (cur[LW-1:0]),
    .pop       (pop),
    .pop_data  (pop_tag),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      query_ready_o   <= 1'b1;
      query_done_o    <= 1'b0;
      query_found_o   <= 1'b0;
      query_latency_o <= '0;
      query_hits_o    <= '0;
      item_q          <= '0;
      target_q        <= '0;
      lo_q            <= '0;
      hi_q            <= '0;
      cur             <= '0;
    end else begin
      query_done_o <= 1'b0;
      // Results popped after the target was reached are drained but not counted.
      if (pop && !query_found_o) begin
        query_hits_o <= hits_next;
        if (hits_next == target_q) begin
          query_found_o   <= 1'b1;
          query_latency_o <= pop_tag;
        end
      end
      case (state)
        S_IDLE: begin
          if (query_i) begin
            item_q          <= query_item_i;
            target_q        <= query_target_i;
            lo_q            <= query_lat_lo_i;
            hi_q            <= query_lat_hi_i;
            cur             <= {1'b0, query_lat_lo_i};
            query_hits_o    <= '0;
            query_found_o   <= 1'b0;
            query_latency_o <= '0;
            query_ready_o   <= 1'b0;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (target_q == '0) begin
            query_found_o   <= 1'b1;
            query_latency_o <= lo_q;
            query_done_o    <= 1'b1;
            state           <= S_DONE;
          end else if (lo_q > hi_q) begin
            query_done_o <= 1'b1;
            state        <= S_DONE;
          end else if (query_found_o) begin
            state <= S_DRAIN;
          end else if (issue_fire) begin
            cur <= cur + (LW+1)'(1);
            if (cur == {1'b0, hi_q}) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_empty) begin
            query_done_o <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          query_ready_o <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef STAGE4_QUERY_PROBE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      query_probes_o <= '0;
    end else if (state == S_IDLE && query_i) begin
      query_probes_o <= '0;
    end else if (issue_fire) begin
      query_probes_o <= query_probes_o + (LW+1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_stage4_query_ctrl.sv
// Directed bench for stage4_query_ctrl with a 2-cycle search-port stub.
module tb_stage4_query_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        query_i;
  logic [63:0] query_item_i;
  logic [7:0]  query_target_i;
  logic [7:0]  query_lat_lo_i;
  logic [7:0]  query_lat_hi_i;
  logic        query_ready_o;
  logic        query_done_o;
  logic        query_found_o;
  logic [7:0]  query_latency_o;
  logic [7:0]  query_hits_o;
  logic        insert_busy_i;
  logic        search_a_o;
  logic [63:0] search_a_data_o;
  logic [63:0] search_a_latency_o;
  logic        search_a_freq_i;
  logic        search_a_end_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc;
  int watch_bkt;
  int watch_cyc;
  int d;
  int probe_q[$];
  int probe_cyc_q[$];
  logic [63:0] probe_item;
  logic        freq_tab [256];
  logic        h_v [3];
  logic [7:0]  h_b [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  stage4_query_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .query_i            (query_i),
    .query_item_i       (query_item_i),
    .query_target_i     (query_target_i),
    .query_lat_lo_i     (query_lat_lo_i),
    .query_lat_hi_i     (query_lat_hi_i),
    .query_ready_o      (query_ready_o),
    .query_done_o       (query_done_o),
    .query_found_o      (query_found_o),
    .query_latency_o    (query_latency_o),
    .query_hits_o       (query_hits_o),
    .insert_busy_i      (insert_busy_i),
    .search_a_o         (search_a_o),
    .search_a_data_o    (search_a_data_o),
    .search_a_latency_o (search_a_latency_o),
    .search_a_freq_i    (search_a_freq_i),
    .search_a_end_i     (search_a_end_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_freq(input logic v);
    for (int i = 0; i < 256; i++) freq_tab[i] = v;
  endtask

  // Search-port stub: a probe seen in cycle c returns its result in cycle c+2.
  initial begin
    search_a_end_i  = 1'b0;
    search_a_freq_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      h_v[i] = 1'b0;
      h_b[i] = '0;
    end
    forever begin
      @(negedge clk);
      #1;
      h_v[2] = h_v[1]; h_b[2] = h_b[1];
      h_v[1] = h_v[0]; h_b[1] = h_b[0];
      h_v[0] = search_a_o;
      h_b[0] = search_a_latency_o[7:0];
      if (search_a_o) begin
        probe_q.push_back(int'(h_b[0]));
        probe_cyc_q.push_back(cyc);
        probe_item = search_a_data_o;
      end
      search_a_end_i  = h_v[2];
      search_a_freq_i = h_v[2] ? freq_tab[h_b[2]] : 1'b0;
      if (h_v[2] && int'(h_b[2]) == watch_bkt) watch_cyc = cyc;
    end
  end

  task automatic start_query(input logic [63:0] item, input logic [7:0] tgt,
                             input logic [7:0] lo, input logic [7:0] hi);
    int n;
    n = 0;
    @(negedge clk);
    while (!query_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", query_ready_o, 1'b1);
    probe_q.delete();
    probe_cyc_q.delete();
    query_item_i   = item;
    query_target_i = tgt;
    query_lat_lo_i = lo;
    query_lat_hi_i = hi;
    query_i        = 1'b1;
    @(negedge clk);
    query_i = 1'b0;
    acc_cyc = cyc;
    chk("ready_low_busy", query_ready_o, 1'b0);
  endtask

  task automatic wait_done(input int busy_lo, input int busy_hi, output int done_rel);
    done_rel = -1;
    for (int k = 0; k < 400; k++) begin
      if (query_done_o) begin
        done_rel = k;
        break;
      end
      insert_busy_i = (k >= busy_lo && k <= busy_hi);
      @(negedge clk);
    end
    insert_busy_i = 1'b0;
    chk("done_seen", done_rel >= 0, 1'b1);
    if (done_rel >= 0) begin
      @(negedge clk);
      chk("done_one_cycle", query_done_o, 1'b0);
      chk("ready_after_done", query_ready_o, 1'b1);
    end
  endtask

  task automatic check_seq(input string tag, input int lo, input int n);
    int ok;
    ok = 1;
    chk({tag, "_probe_cnt"}, probe_q.size(), n);
    foreach (probe_q[i]) if (probe_q[i] != lo + i) ok = 0;
    chk({tag, "_probe_seq"}, ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; query_i = 1'b0; query_item_i = '0; query_target_i = '0;
    query_lat_lo_i = '0; query_lat_hi_i = '0; insert_busy_i = 1'b0;
    watch_bkt = -1; watch_cyc = 0; probe_item = '0;
    clear_freq(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_ready", query_ready_o, 1'b1);
    chk("rst_done", query_done_o, 1'b0);
    chk("rst_found", query_found_o, 1'b0);
    chk("rst_latency", query_latency_o, 0);
    chk("rst_hits", query_hits_o, 0);
    chk("rst_search", search_a_o, 1'b0);
    chk("rst_sdata", search_a_data_o, 0);
    chk("rst_slat", search_a_latency_o, 0);
    rst = 1'b0;

    // Hits at 2,4,5 reach target 3 at bucket 5.
    clear_freq(1'b0);
    freq_tab[2] = 1'b1; freq_tab[4] = 1'b1; freq_tab[5] = 1'b1;
    watch_bkt = 5; watch_cyc = 0;
    start_query(64'h1111_2222_3333_4444, 8'd3, 8'd0, 8'd7);
    wait_done(-1, -1, d);
    chk("a_found", query_found_o, 1'b1);
    chk("a_latency", query_latency_o, 5);
    chk("a_hits", query_hits_o, 3);
    chk("a_item", probe_item, 64'h1111_2222_3333_4444);
    chk("a_stop", probe_cyc_q.size() > 0 && probe_cyc_q[$] <= watch_cyc + 1, 1'b1);
    check_seq("a", 0, probe_q.size());

    // Wider range: results past the hit (6,7,10) must not count.
    freq_tab[6] = 1'b1; freq_tab[7] = 1'b1; freq_tab[10] = 1'b1;
    start_query(64'hDEAD_BEEF_0000_0001, 8'd3, 8'd0, 8'd20);
    wait_done(-1, -1, d);
    repeat (3) @(negedge clk);
    chk("a2_found", query_found_o, 1'b1);
    chk("a2_latency", query_latency_o, 5);
    chk("a2_hits", query_hits_o, 3);
    chk("a2_stop", probe_cyc_q.size() > 0 && probe_cyc_q[$] <= watch_cyc + 1, 1'b1);
    chk("a2_first", probe_q.size() > 0 && probe_q[0] == 0, 1'b1);
    watch_bkt = -1;

    // Target never reached; a second query_i mid-run is ignored.
    clear_freq(1'b0);
    freq_tab[1] = 1'b1;
    start_query(64'h0000_0000_0000_00B0, 8'd2, 8'd0, 8'd3);
    query_item_i = 64'h0; query_target_i = 8'd0;
    query_lat_lo_i = 8'd100; query_lat_hi_i = 8'd100;
    query_i = 1'b1;
    @(negedge clk);
    query_i = 1'b0;
    wait_done(-1, -1, d);
    chk("b_found", query_found_o, 1'b0);
    chk("b_hits", query_hits_o, 1);
    chk("b_latency", query_latency_o, 0);
    check_seq("b", 0, 4);

    // Zero target and empty range finish without probing.
    start_query(64'h0000_0000_0000_00C0, 8'd0, 8'd5, 8'd9);
    wait_done(-1, -1, d);
    chk("c_done_lat", d, 1);
    chk("c_found", query_found_o, 1'b1);
    chk("c_latency", query_latency_o, 5);
    chk("c_probes", probe_q.size(), 0);
    start_query(64'h0000_0000_0000_00C1, 8'd2, 8'd9, 8'd3);
    wait_done(-1, -1, d);
    chk("c2_found", query_found_o, 1'b0);
    chk("c2_latency", query_latency_o, 0);
    chk("c2_probes", probe_q.size(), 0);

    // Insert busy in cycles 2..4 stalls probing without gaps or repeats.
    clear_freq(1'b0);
    start_query(64'hA5A5_0000_1234_5678, 8'd5, 8'd10, 8'd17);
    wait_done(2, 4, d);
    check_seq("d", 10, 8);
    begin
      int hit_busy;
      hit_busy = 0;
      foreach (probe_cyc_q[i]) begin
        if (probe_cyc_q[i] - acc_cyc >= 2 && probe_cyc_q[i] - acc_cyc <= 4) hit_busy = 1;
      end
      chk("d_no_probe_busy", hit_busy, 0);
    end
    chk("d_found", query_found_o, 1'b0);
    chk("d_item", probe_item, 64'hA5A5_0000_1234_5678);

    // Top of bucket range terminates without wrapping.
    start_query(64'h0000_0000_0000_00E0, 8'd1, 8'd250, 8'd255);
    wait_done(-1, -1, d);
    check_seq("e", 250, 6);
    chk("e_found", query_found_o, 1'b0);
    chk("e_hits", query_hits_o, 0);

    // Reset mid-issue with results in flight.
    clear_freq(1'b1);
    start_query(64'h0000_0000_0000_00F0, 8'd9, 8'd0, 8'd30);
    repeat (4) @(negedge clk);
    chk("f_probe_live", search_a_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("f_ready", query_ready_o, 1'b1);
    chk("f_done", query_done_o, 1'b0);
    chk("f_hits", query_hits_o, 0);
    chk("f_found", query_found_o, 1'b0);
    chk("f_search", search_a_o, 1'b0);
    repeat (3) @(negedge clk);
    chk("f_stale_hits", query_hits_o, 0);
    chk("f_stale_ready", query_ready_o, 1'b1);
    clear_freq(1'b0);
    freq_tab[1] = 1'b1; freq_tab[3] = 1'b1;
    start_query(64'h0000_0000_0000_00F1, 8'd2, 8'd0, 8'd3);
    wait_done(-1, -1, d);
    chk("f2_found", query_found_o, 1'b1);
    chk("f2_latency", query_latency_o, 3);
    chk("f2_hits", query_hits_o, 2);
    check_seq("f2", 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
